// File: rtl/instr_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : instr_buffer
// Purpose  : Circular instruction buffer between fetch and decode. Accepts up
//            to four entries per cycle and presents the two oldest entries
//            to decode, which consumes up to two per cycle.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   single clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   flush_IB       in   synchronous clear of all entries (beats push/pop)
//   if1_to_ib      in   four candidate entries, slot 0 in the LSBs
//   push_num       in   number of slots (0..4) to enqueue
//   can_push_size  out  registered occupancy (0..depth)
//   ib_out         out  head entry in LSBs, head+1 in MSBs
//   ib_out_valid   out  bit0 head valid, bit1 head+1 valid
//   pop_num        in   entries (0..2) consumed by decode
//   push_err       out  one-cycle pulse after a rejected push
// Entry layout: {pc_valid, pc_is_jump, pc[31:0], instr[31:0]}
// ============================================================================
module instr_buffer #(
  parameter int IB_WIDTH_LOG2  = 4,
  parameter int IB_DATA_BUS_WD = 66
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush_IB,
  input  logic [4*IB_DATA_BUS_WD-1:0] if1_to_ib,
  input  logic [2:0]                  push_num,
  output logic [IB_WIDTH_LOG2:0]      can_push_size,
  output logic [2*IB_DATA_BUS_WD-1:0] ib_out,
  output logic [1:0]                  ib_out_valid,
  input  logic [1:0]                  pop_num,
  output logic                        push_err
);

  localparam int            DEPTH   = 1 << IB_WIDTH_LOG2;
  localparam int            CW      = IB_WIDTH_LOG2 + 1;
  localparam int            PW      = IB_WIDTH_LOG2;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [IB_DATA_BUS_WD-1:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] rd_ptr_nxt;
  logic [CW-1:0] count_q, count_d;
  logic          push_err_q, push_err_d;

  logic [CW-1:0] free;
  logic [CW-1:0] push_amt;
  logic [CW-1:0] pop_amt;
  logic          push_ok;
  logic [PW-1:0] wr_idx [4];
  logic [3:0]    wr_en;

  always_comb begin
    // Room is judged on the pre-pop occupancy: a same-cycle pop frees nothing.
    free     = DEPTH_C - count_q;
    push_ok  = (push_num <= 3'd4) && (32'(push_num) <= 32'(free));
    push_amt = push_ok ? CW'(push_num) : '0;
    pop_amt  = (CW'(pop_num) > count_q) ? count_q : CW'(pop_num);

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    push_err_d = 1'b0;
    wr_en      = '0;

    for (int i = 0; i < 4; i++) begin
      wr_idx[i] = wr_ptr_q + PW'(i);
    end

    if (flush_IB) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        wr_en[i] = push_ok && (3'(i) < push_num);
      end
      wr_ptr_d   = wr_ptr_q + push_amt[PW-1:0];
      rd_ptr_d   = rd_ptr_q + pop_amt[PW-1:0];
      count_d    = count_q + push_amt - pop_amt;
      push_err_d = !push_ok;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      push_err_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      push_err_q <= push_err_d;
    end
  end

  // Storage carries no reset; an entry is only observable once written.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en[i]) begin
        mem_q[wr_idx[i]] <= if1_to_ib[i*IB_DATA_BUS_WD +: IB_DATA_BUS_WD];
      end
    end
  end

  assign rd_ptr_nxt    = rd_ptr_q + PW'(1);
  assign ib_out        = {mem_q[rd_ptr_nxt], mem_q[rd_ptr_q]};
  assign ib_out_valid  = {(count_q >= CW'(2)), (count_q != '0)};
  assign can_push_size = count_q;
  assign push_err      = push_err_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_instr_buffer
// Purpose  : Self-checking bench for instr_buffer. A table of steps gives the
//            inputs plus hand-derived occupancy / valid / push_err after each
//            edge; a queue scoreboard tracks the entries that should be held
//            and compares them against ib_out before decode consumes them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_buffer;

  localparam int W = 66;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           flush_IB;
  logic [4*W-1:0] if1_to_ib;
  logic [2:0]     push_num;
  logic [4:0]     can_push_size;
  logic [2*W-1:0] ib_out;
  logic [1:0]     ib_out_valid;
  logic [1:0]     pop_num;
  logic           push_err;

  instr_buffer #(.IB_WIDTH_LOG2(4), .IB_DATA_BUS_WD(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_IB     (flush_IB),
    .if1_to_ib    (if1_to_ib),
    .push_num     (push_num),
    .can_push_size(can_push_size),
    .ib_out       (ib_out),
    .ib_out_valid (ib_out_valid),
    .pop_num      (pop_num),
    .push_err     (push_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       flush;
    logic [2:0] push;
    logic [1:0] pop;
    int         exp_count;
    logic       exp_err;
    logic [1:0] exp_valid;
  } vec_t;

  vec_t         vecs[$];
  logic [W-1:0] model_q[$];
  int           k = 0;
  int           checks = 0;
  int           errors = 0;

  function automatic logic [W-1:0] make_entry(input int n);
    logic [31:0] pc;
    logic [31:0] ins;
    pc  = 32'h1c00_0000 + 32'(n) * 32'd4;
    ins = (32'(n) * 32'h9e37_79b9) ^ 32'h0000_0013;
    // pc_valid alternates so invalid entries travel through as plain data.
    return {~pc[2], pc[3], pc, ins};
  endfunction

  task automatic chk(input string name, input logic [131:0] act, input logic [131:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic fl, input logic [2:0] pn, input logic [1:0] pp,
                     input int ec, input logic ee, input logic [1:0] ev);
    vec_t v;
    v.flush = fl; v.push = pn; v.pop = pp;
    v.exp_count = ec; v.exp_err = ee; v.exp_valid = ev;
    vecs.push_back(v);
  endtask

  // One cycle: drive at negedge, check held entries, advance model at edge.
  task automatic step(input logic fl, input logic [2:0] pn, input logic [1:0] pp);
    int sz;
    int eff;
    @(negedge clk);
    flush_IB = fl;
    push_num = pn;
    pop_num  = pp;
    for (int s = 0; s < 4; s++) if1_to_ib[s*W +: W] = make_entry(k + s);
    #1;
    for (int j = 0; j < 2; j++) begin
      if (j < model_q.size()) chk($sformatf("head%0d", j), 132'(ib_out[j*W +: W]), 132'(model_q[j]));
    end
    @(posedge clk);
    sz = model_q.size();
    if (fl) begin
      model_q.delete();
    end else begin
      eff = (int'(pp) < sz) ? int'(pp) : sz;
      for (int j = 0; j < eff; j++) void'(model_q.pop_front());
      if (pn <= 3'd4 && int'(pn) <= 16 - sz) begin
        for (int s = 0; s < int'(pn); s++) model_q.push_back(make_entry(k + s));
        k += int'(pn);
      end
    end
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush_IB  = 1'b0;
    push_num  = '0;
    pop_num   = '0;
    if1_to_ib = '0;
    #12;
    chk("reset_count", 132'(can_push_size), 132'd0);
    chk("reset_valid", 132'(ib_out_valid), 132'd0);
    chk("reset_err",   132'(push_err), 132'd0);
    @(negedge clk);
    rst_n = 1'b1;

    //  flush push pop  count err valid
    add(0, 4, 0,  4, 0, 2'b11);   // fill 4 from empty
    add(0, 0, 2,  2, 0, 2'b11);
    add(0, 0, 2,  0, 0, 2'b00);
    add(0, 4, 0,  4, 0, 2'b11);   // advance pointers toward 14
    add(0, 4, 2,  6, 0, 2'b11);
    add(0, 2, 2,  6, 0, 2'b11);
    add(0, 0, 2,  4, 0, 2'b11);
    add(0, 0, 2,  2, 0, 2'b11);
    add(0, 0, 2,  0, 0, 2'b00);   // rd = wr = 14
    add(0, 4, 0,  4, 0, 2'b11);   // wraps into 14,15,0,1
    add(0, 0, 1,  3, 0, 2'b11);
    add(0, 0, 1,  2, 0, 2'b11);
    add(0, 0, 1,  1, 0, 2'b01);
    add(0, 0, 1,  0, 0, 2'b00);
    add(0, 1, 0,  1, 0, 2'b01);
    add(0, 0, 2,  0, 0, 2'b00);   // pop 2 with only 1 held
    add(0, 0, 2,  0, 0, 2'b00);   // pop on empty
    add(0, 4, 0,  4, 0, 2'b11);
    add(0, 4, 0,  8, 0, 2'b11);
    add(0, 4, 0, 12, 0, 2'b11);
    add(0, 4, 0, 16, 0, 2'b11);   // exact fill
    add(0, 0, 0, 16, 0, 2'b11);   // push 0 at full
    add(0, 1, 0, 16, 1, 2'b11);   // overflow
    add(0, 0, 2, 14, 0, 2'b11);
    add(0, 3, 2, 12, 1, 2'b11);   // pop gives no extra room
    add(0, 0, 0, 12, 0, 2'b11);
    add(0, 5, 0, 12, 1, 2'b11);   // illegal push_num
    add(0, 7, 1, 11, 1, 2'b11);
    add(0, 0, 2,  9, 0, 2'b11);
    add(0, 6, 1,  8, 1, 2'b11);
    add(1, 4, 2,  0, 0, 2'b00);   // flush wins over push/pop
    add(0, 4, 0,  4, 0, 2'b11);
    add(0, 0, 2,  2, 0, 2'b11);
    add(0, 0, 2,  0, 0, 2'b00);

    for (int r = 0; r < vecs.size(); r++) begin
      step(vecs[r].flush, vecs[r].push, vecs[r].pop);
      chk($sformatf("count[%0d]", r), 132'(can_push_size), 132'(vecs[r].exp_count));
      chk($sformatf("valid[%0d]", r), 132'(ib_out_valid), 132'(vecs[r].exp_valid));
      chk($sformatf("err[%0d]", r),   132'(push_err), 132'(vecs[r].exp_err));
      if (r == 0) begin
        chk("pc_head0", 132'(ib_out[63:32]),  132'(32'h1c00_0000));
        chk("pc_head1", 132'(ib_out[129:98]), 132'(32'h1c00_0004));
      end
      if (r == 1) begin
        chk("pc_head0_after_pop", 132'(ib_out[63:32]),  132'(32'h1c00_0008));
        chk("pc_head1_after_pop", 132'(ib_out[129:98]), 132'(32'h1c00_000c));
      end
    end

    // Asynchronous reset in the middle of traffic with push_err raised.
    step(0, 4, 0);
    step(0, 7, 0);
    chk("pre_rst_err", 132'(push_err), 132'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_count", 132'(can_push_size), 132'd0);
    chk("mid_rst_valid", 132'(ib_out_valid), 132'd0);
    chk("mid_rst_err",   132'(push_err), 132'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_q.delete();
    step(0, 2, 0);
    chk("post_rst_count", 132'(can_push_size), 132'd2);
    chk("post_rst_valid", 132'(ib_out_valid), 132'd3);
    step(0, 0, 2);
    chk("post_rst_drain", 132'(can_push_size), 132'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
